// File: rtl/obi_rvalid_stall_gen_if.sv
// obi_rvalid_stall_gen_if: OBI request/response signals between the harness and the stall model.
interface obi_rvalid_stall_gen_if #(parameter int DATA_WIDTH = 32);
    logic                  req_i;
    logic                  gnt_i;
    logic                  we_i;
    logic [DATA_WIDTH-1:0] rdata_i;
    logic                  gnt_o;
    logic                  rvalid_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    modport slave  (input req_i, gnt_i, we_i, rdata_i, output gnt_o, rdata_o, rvalid_o);
    modport master (output req_i, gnt_i, we_i, rdata_i, input gnt_o, rdata_o, rvalid_o);
endinterface

// File: rtl/obi_rvalid_stall_gen.sv
// obi_rvalid_stall_gen: in-order OBI response FIFO with programmable per-entry rvalid delay.
module obi_rvalid_stall_gen #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          DEPTH       = 8,
    parameter int          DELAY_WIDTH = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         IW          = $clog2(DEPTH),
    localparam int         PW          = IW + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    obi_rvalid_stall_gen_if.slave  bus,
    input  logic                   en_stall_i,
    input  logic [1:0]             stall_mode_i,
    input  logic [DELAY_WIDTH-1:0] max_stall_i,
    input  logic [DELAY_WIDTH-1:0] valid_stall_i,
    output logic                   full_o,
    output logic [PW-1:0]          count_o,
    output logic                   overflow_o
);
    localparam logic [1:0] MODE_NONE  = 2'd0;
    localparam logic [1:0] MODE_FIXED = 2'd1;
    localparam logic [1:0] MODE_RAND  = 2'd2;

    logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic                   cap_q, cap_d, ovf_q, ovf_d;
    logic [IW-1:0]          cap_idx_q, cap_idx_d;
    logic                   we_q   [DEPTH];
    logic                   dv_q   [DEPTH];
    logic [DELAY_WIDTH-1:0] dly_q  [DEPTH];
    logic [DATA_WIDTH-1:0]  data_q [DEPTH];
    logic                   push, pop, empty, head_cap;
    logic [IW-1:0]          widx, head;
    logic [DELAY_WIDTH-1:0] rnd, new_dly;

    assign widx       = wptr_q[IW-1:0];
    assign head       = rptr_q[IW-1:0];
    assign empty      = wptr_q == rptr_q;
    assign full_o     = (widx == head) && (wptr_q[IW] != rptr_q[IW]);
    assign count_o    = wptr_q - rptr_q;
    assign overflow_o = ovf_q;
    assign bus.gnt_o  = bus.gnt_i && !full_o;
    assign push       = bus.req_i && bus.gnt_o;
    // A head whose read data arrives this cycle may respond immediately via bypass.
    assign head_cap     = cap_q && (cap_idx_q == head);
    assign pop          = !empty && (dly_q[head] == '0) && (dv_q[head] || head_cap);
    assign bus.rvalid_o = pop;
    assign bus.rdata_o  = (!pop || we_q[head]) ? '0 : head_cap ? bus.rdata_i : data_q[head];
    assign rnd          = lfsr_q[DELAY_WIDTH-1:0];

    always_comb begin
        new_dly   = (!en_stall_i || stall_mode_i == MODE_NONE) ? '0 :
                    (stall_mode_i == MODE_FIXED) ? valid_stall_i :
                    (stall_mode_i == MODE_RAND) ? ((rnd < max_stall_i) ? rnd : max_stall_i) :
                    max_stall_i;
        wptr_d    = wptr_q + PW'(push);
        rptr_d    = rptr_q + PW'(pop);
        cap_d     = push && !bus.we_i;
        cap_idx_d = widx;
        ovf_d     = ovf_q || (bus.req_i && bus.gnt_i && full_o);
        lfsr_d    = (en_stall_i && stall_mode_i == MODE_RAND) ?
                    {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cap_q     <= 1'b0;
            cap_idx_q <= '0;
            ovf_q     <= 1'b0;
            lfsr_q    <= LFSR_SEED;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cap_q     <= cap_d;
            cap_idx_q <= cap_idx_d;
            ovf_q     <= ovf_d;
            lfsr_q    <= lfsr_d;
        end
    end

    // Capture, push and head countdown never collide on one index unless the FIFO is empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                we_q[i]   <= 1'b0;
                dv_q[i]   <= 1'b0;
                dly_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (!empty && dly_q[head] != '0)
                dly_q[head] <= dly_q[head] - DELAY_WIDTH'(1);
            if (cap_q) begin
                data_q[cap_idx_q] <= bus.rdata_i;
                dv_q[cap_idx_q]   <= 1'b1;
            end
            if (push) begin
                we_q[widx]   <= bus.we_i;
                dly_q[widx]  <= new_dly;
                dv_q[widx]   <= bus.we_i;
                data_q[widx] <= '0;
            end
        end
    end
endmodule

// File: tb/tb_obi_rvalid_stall_gen.sv
// tb_obi_rvalid_stall_gen: directed stimulus with a scoreboard queue checked by a response monitor.
module tb_obi_rvalid_stall_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en;
    logic [1:0] mode;
    logic [3:0] mx, vs;
    logic       full, ovf;
    logic [3:0] cnt;

    always #5 clk = ~clk;

    obi_rvalid_stall_gen_if #(.DATA_WIDTH(32)) bus();

    obi_rvalid_stall_gen #(.DATA_WIDTH(32), .DEPTH(8), .DELAY_WIDTH(4), .LFSR_SEED(16'hACE1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus), .en_stall_i(en), .stall_mode_i(mode),
        .max_stall_i(mx), .valid_stall_i(vs), .full_o(full), .count_o(cnt), .overflow_o(ovf)
    );

    typedef struct {int g; int d; logic [31:0] data;} exp_t;

    int          checks = 0, errors = 0, cyc = 0, prev = -1, mh;
    exp_t        sb[$], me;
    bit          rec = 1'b0;
    int          lats[$], lats0[$];
    logic [15:0] m_lfsr;
    logic        pend_v = 1'b0;
    logic [31:0] pend_d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= 16'hACE1;
        else if (en && mode == 2'd2) m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    function automatic int dly_of();
        if (!en || mode == 2'd0) return 0;
        if (mode == 2'd1) return int'(vs);
        if (mode == 2'd2) return (m_lfsr[3:0] < mx) ? int'(m_lfsr[3:0]) : int'(mx);
        return int'(mx);
    endfunction

    always @(negedge clk) if (rst_n) begin
        if (bus.rvalid_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got rvalid with rdata %0h at cycle %0d, expected none", bus.rdata_o, cyc);
            end else begin
                me = sb.pop_front();
                mh = (me.g + 1 > prev + 1) ? me.g + 1 : prev + 1;
                chk("resp_cycle", cyc, mh + me.d);
                chk("resp_data", bus.rdata_o, me.data);
                if (rec) begin
                    lats.push_back(cyc - me.g);
                    chk("rand_latency_range", (cyc - me.g >= 1) && (cyc - me.g <= 6), 1);
                end
                prev = cyc;
            end
        end else chk("idle_rdata", bus.rdata_o, 0);
    end

    task automatic step(input logic r, input logic w, input logic [31:0] d, input logic acc);
        bus.rdata_i = pend_v ? pend_d : 32'hBADBAD00;
        bus.req_i   = r;
        bus.gnt_i   = r;
        bus.we_i    = w;
        @(negedge clk);
        chk("gnt_o", bus.gnt_o, r && acc);
        if (r && acc) sb.push_back('{cyc, dly_of(), w ? 32'h0 : d});
        pend_v = r && acc && !w;
        pend_d = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic drain(input int limit);
        int k = 0;
        while (sb.size() != 0 && k < limit) begin
            idle(1);
            k++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    task automatic do_reset();
        bus.req_i = 1'b0;
        bus.gnt_i = 1'b0;
        bus.we_i  = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_rvalid", bus.rvalid_o, 0);
        chk("rst_rdata", bus.rdata_o, 0);
        chk("rst_count", cnt, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", ovf, 0);
        chk("rst_gnt", bus.gnt_o, 0);
        sb.delete();
        prev   = -1;
        pend_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int diff;
        en = 1'b0; mode = 2'd0; mx = '0; vs = '0;
        bus.req_i = 1'b0; bus.gnt_i = 1'b0; bus.we_i = 1'b0; bus.rdata_i = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Mode 0 back-to-back reads, one cycle latency each.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h11 * (i + 1), 1'b1);
            chk("t1_count", cnt, 1);
        end
        idle(1);
        chk("t1_count_end", cnt, 0);
        drain(20);

        // Fixed delay 3: read then write, both four cycles after grant.
        en = 1'b1; mode = 2'd1; vs = 4'd3;
        step(1'b1, 1'b0, 32'hDEADBEEF, 1'b1);
        idle(6);
        step(1'b1, 1'b1, 32'h12345678, 1'b1);
        idle(6);
        drain(20);

        // Max mode fills the FIFO; ninth request overflows.
        mode = 2'd3; mx = 4'd15;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'hA0 + i, 1'b1);
        chk("t3_full", full, 1);
        chk("t3_count", cnt, 8);
        chk("t3_ovf_before", ovf, 0);
        step(1'b1, 1'b0, 32'hFF, 1'b0);
        chk("t3_ovf_after", ovf, 1);
        chk("t3_full_hold", full, 1);
        drain(200);
        chk("t3_ovf_sticky", ovf, 1);
        chk("t3_count_end", cnt, 0);

        // Reset with entries outstanding discards them.
        mode = 2'd1; vs = 4'd7;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hC0 + i, 1'b1);
        idle(2);
        chk("t5_count_pre", cnt, 3);
        do_reset();
        idle(12);
        en = 1'b0; mode = 2'd0;
        step(1'b1, 1'b0, 32'h5A5A5A5A, 1'b1);
        drain(5);

        // Alternating reads and writes wrap the pointers.
        for (int i = 0; i < 20; i++) step(1'b1, i[0], 32'h100 + i, 1'b1);
        drain(5);
        chk("t6_count_end", cnt, 0);
        chk("t6_full_end", full, 0);

        // Random mode twice from the same seed must repeat exactly.
        for (int run = 0; run < 2; run++) begin
            do_reset();
            lats.delete();
            rec = 1'b1;
            en = 1'b1; mode = 2'd2; mx = 4'd5;
            for (int i = 0; i < 200; i++) begin
                step(1'b1, 1'b0, $urandom, 1'b1);
                idle(6);
            end
            drain(20);
            rec = 1'b0;
            if (run == 0) lats0 = lats;
        end
        chk("rand_count_run0", lats0.size(), 200);
        chk("rand_count_run1", lats.size(), 200);
        diff = 0;
        foreach (lats[i]) if (i < lats0.size() && lats[i] != lats0[i]) diff++;
        chk("rand_repeatable", diff, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
